// File: rtl/avalon_channel_fifos.sv
// avalon_channel_fifos
//   Avalon-MM ingress buffer. Host writes to addresses 1..CHANNELS push one
//   word into the matching FIFO; each FIFO is drained through a show-ahead
//   pop interface. Also provides overflow drop counters with a sticky
//   any-drop flag, per-channel flush, and host-readable status/occupancy.
//
// Parameters
//   DATA_W    stored word width (1..32)
//   CHANNELS  number of FIFOs (1..7)
//   DEPTH     words per FIFO (power of two, >= 2)
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   chipselect        Avalon select; qualifies write and read
//   write, read       Avalon strobes
//   address[3:0]      0 status (rd), 1..CHANNELS push (wr),
//                     8+c channel c drops/occupancy (rd), 15 control (wr)
//   writedata[31:0]   push data / control word (flush mask, bit 31 clear)
//   readdata[31:0]    registered read data, 1-cycle latency
//   pop[CHANNELS]     per-channel dequeue request
//   q                 head word per channel, channel c at [c*DATA_W +: DATA_W]
//   empty, full       per-channel flags derived from registered occupancy
module avalon_channel_fifos #(
    parameter int DATA_W   = 32,
    parameter int CHANNELS = 3,
    parameter int DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       chipselect,
    input  logic                       write,
    input  logic                       read,
    input  logic [3:0]                 address,
    input  logic [31:0]                writedata,
    output logic [31:0]                readdata,
    input  logic [CHANNELS-1:0]        pop,
    output logic [CHANNELS*DATA_W-1:0] q,
    output logic [CHANNELS-1:0]        empty,
    output logic [CHANNELS-1:0]        full
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

    logic [DATA_W-1:0] mem [CHANNELS][DEPTH];
    logic [AW-1:0]     wr_ptr [CHANNELS];
    logic [AW-1:0]     rd_ptr [CHANNELS];
    logic [OW-1:0]     occ [CHANNELS];
    logic [15:0]       drop_cnt [CHANNELS];
    logic              any_drop;

    logic                wr_valid;
    logic                rd_valid;
    logic                ctrl_wr;
    logic                clear_drops;
    logic [CHANNELS-1:0] push_sel;
    logic [CHANNELS-1:0] do_push;
    logic [CHANNELS-1:0] do_pop;
    logic [CHANNELS-1:0] drop_evt;
    logic [CHANNELS-1:0] flush;
    logic [31:0]         status_word;
    logic [31:0]         rd_word;

    // Write data bits above DATA_W (other than the clear bit) carry no meaning.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    always_comb begin
        wr_valid    = chipselect && write;
        rd_valid    = chipselect && read;
        ctrl_wr     = wr_valid && (address == 4'd15);
        clear_drops = ctrl_wr && writedata[31];
    end

    // Flags come only from registered occupancy, so pop and the bus never
    // reach empty/full combinationally. Full is judged before any same-cycle
    // pop, which is why a push to a full FIFO drops even while it is popped.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            empty[c]    = (occ[c] == '0);
            full[c]     = (occ[c] == OCC_FULL);
            push_sel[c] = wr_valid && (address == 4'(c + 1));
            flush[c]    = ctrl_wr && writedata[c];
            do_push[c]  = push_sel[c] && (occ[c] != OCC_FULL);
            drop_evt[c] = push_sel[c] && (occ[c] == OCC_FULL);
            do_pop[c]   = pop[c] && (occ[c] != '0) && !writedata_flush(c);
        end
    end

    // Flush wins over pop; wrapped in a function so the pop term above does
    // not read back the flush vector assigned in the same block.
    function automatic logic writedata_flush(input int c);
        return ctrl_wr && writedata[c];
    endfunction

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            q[c*DATA_W +: DATA_W] = mem[c][rd_ptr[c]];
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (do_push[c]) begin
                mem[c][wr_ptr[c]] <= writedata[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr[c]   <= '0;
                rd_ptr[c]   <= '0;
                occ[c]      <= '0;
                drop_cnt[c] <= '0;
            end
            any_drop <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (flush[c]) begin
                    wr_ptr[c] <= '0;
                    rd_ptr[c] <= '0;
                    occ[c]    <= '0;
                end else begin
                    if (do_push[c]) begin
                        wr_ptr[c] <= wr_ptr[c] + AW'(1);
                    end
                    if (do_pop[c]) begin
                        rd_ptr[c] <= rd_ptr[c] + AW'(1);
                    end
                    if (do_push[c] && !do_pop[c]) begin
                        occ[c] <= occ[c] + OW'(1);
                    end else if (!do_push[c] && do_pop[c]) begin
                        occ[c] <= occ[c] - OW'(1);
                    end
                end
                // Clear beats a same-cycle increment; the counter saturates.
                if (clear_drops) begin
                    drop_cnt[c] <= '0;
                end else if (drop_evt[c] && (drop_cnt[c] != 16'hFFFF)) begin
                    drop_cnt[c] <= drop_cnt[c] + 16'd1;
                end
            end
            if (clear_drops) begin
                any_drop <= 1'b0;
            end else if (|drop_evt) begin
                any_drop <= 1'b1;
            end
        end
    end

    // Read mux sees pre-edge state, so a read alongside a push returns the
    // values from before that push.
    always_comb begin
        status_word = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            status_word[c]     = empty[c];
            status_word[8 + c] = full[c];
        end
        status_word[16] = any_drop;

        rd_word = '0;
        if (address == 4'd0) begin
            rd_word = status_word;
        end
        for (int c = 0; c < CHANNELS; c++) begin
            if (address == 4'(8 + c)) begin
                rd_word = {drop_cnt[c], 16'(occ[c])};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (rd_valid) begin
            readdata <= rd_word;
        end
    end

endmodule

// File: tb/tb_avalon_channel_fifos.sv
module tb_avalon_channel_fifos;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // DUT 0: default parameters
    logic        cs0 = 0, wr0 = 0, rd0 = 0;
    logic [3:0]  addr0 = 0;
    logic [31:0] wd0 = 0;
    logic [31:0] rdata0;
    logic [2:0]  pop0 = 0;
    logic [95:0] q0;
    logic [2:0]  empty0, full0;

    // DUT 1: DATA_W=16, DEPTH=8, CHANNELS=7
    logic         cs1 = 0, wr1 = 0, rd1 = 0;
    logic [3:0]   addr1 = 0;
    logic [31:0]  wd1 = 0;
    logic [31:0]  rdata1;
    logic [6:0]   pop1 = 0;
    logic [111:0] q1;
    logic [6:0]   empty1, full1;

    avalon_channel_fifos dut0 (
        .clk(clk), .reset(reset), .chipselect(cs0), .write(wr0), .read(rd0),
        .address(addr0), .writedata(wd0), .readdata(rdata0), .pop(pop0),
        .q(q0), .empty(empty0), .full(full0)
    );

    avalon_channel_fifos #(.DATA_W(16), .CHANNELS(7), .DEPTH(8)) dut1 (
        .clk(clk), .reset(reset), .chipselect(cs1), .write(wr1), .read(rd1),
        .address(addr1), .writedata(wd1), .readdata(rdata1), .pop(pop1),
        .q(q1), .empty(empty1), .full(full1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per channel plus drop counts.
    int          mdepth [2] = '{4, 8};
    int          mch    [2] = '{3, 7};
    logic [31:0] mmask  [2] = '{32'hFFFF_FFFF, 32'h0000_FFFF};
    logic [31:0] mq [2][7][$];
    int          mdrop [2][7];
    bit          many [2];

    function automatic void model_reset(input int d);
        for (int c = 0; c < 7; c++) begin
            mq[d][c].delete();
            mdrop[d][c] = 0;
        end
        many[d] = 0;
    endfunction

    function automatic void model_step(input int d, input bit w, input logic [3:0] a,
                                       input logic [31:0] wd, input logic [6:0] pm);
        int pre [7];
        bit ctrl;
        logic [31:0] tmp;
        ctrl = w && (a == 4'd15);
        for (int c = 0; c < mch[d]; c++) pre[c] = mq[d][c].size();
        for (int c = 0; c < mch[d]; c++) begin
            if (ctrl && wd[c]) mq[d][c].delete();
            else if (pm[c] && pre[c] > 0) tmp = mq[d][c].pop_front();
        end
        if (ctrl && wd[31]) begin
            for (int c = 0; c < 7; c++) mdrop[d][c] = 0;
            many[d] = 0;
        end
        if (w && a >= 4'd1 && int'(a) <= mch[d]) begin
            int c;
            c = int'(a) - 1;
            if (pre[c] == mdepth[d]) begin
                if (mdrop[d][c] < 65535) mdrop[d][c]++;
                many[d] = 1;
            end else begin
                mq[d][c].push_back(wd & mmask[d]);
            end
        end
    endfunction

    function automatic logic [31:0] exp_read(input int d, input logic [3:0] a);
        logic [31:0] r;
        r = '0;
        if (a == 4'd0) begin
            for (int c = 0; c < mch[d]; c++) begin
                r[c]     = (mq[d][c].size() == 0);
                r[8 + c] = (mq[d][c].size() == mdepth[d]);
            end
            r[16] = many[d];
        end else if (a >= 4'd8 && int'(a) - 8 < mch[d]) begin
            r = {16'(mdrop[d][int'(a) - 8]), 16'(mq[d][int'(a) - 8].size())};
        end
        return r;
    endfunction

    // One bus cycle; entered and left at a falling edge.
    task automatic cyc(input int d, input bit cs, input bit w, input bit r,
                       input logic [3:0] a, input logic [31:0] wd, input logic [6:0] pm);
        if (d == 0) begin
            cs0 = cs; wr0 = w; rd0 = r; addr0 = a; wd0 = wd; pop0 = pm[2:0];
        end else begin
            cs1 = cs; wr1 = w; rd1 = r; addr1 = a; wd1 = wd; pop1 = pm;
        end
        @(posedge clk);
        model_step(d, cs && w, a, wd, pm);
        @(negedge clk);
        cs0 = 0; wr0 = 0; rd0 = 0; pop0 = 0;
        cs1 = 0; wr1 = 0; rd1 = 0; pop1 = 0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (empty0 !== 3'b111) begin errors++; $display("FAIL reset_empty got=%b exp=111", empty0); end
        checks++; if (full0 !== 3'b000) begin errors++; $display("FAIL reset_full got=%b exp=000", full0); end
        checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL reset_readdata got=%h exp=0", rdata0); end
        checks++; if (empty1 !== 7'h7F) begin errors++; $display("FAIL reset_empty1 got=%b exp=1111111", empty1); end
        reset = 1'b0;
        model_reset(0); model_reset(1);
        @(negedge clk);
        cyc(0, 1, 1, 0, 4'd1, 32'h11, 0);
        cyc(0, 1, 1, 0, 4'd1, 32'h22, 0);
        cyc(0, 1, 0, 1, 4'd8, 0, 0);
        checks++; if (rdata0 !== 32'h0000_0002) begin errors++; $display("FAIL pre_reset_occ got=%h exp=00000002", rdata0); end
        checks++; if (empty0 !== 3'b110) begin errors++; $display("FAIL pre_reset_empty got=%b exp=110", empty0); end
        // asynchronous reset between edges
        #2 reset = 1'b1;
        #1;
        checks++; if (empty0 !== 3'b111) begin errors++; $display("FAIL async_empty got=%b exp=111", empty0); end
        checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL async_readdata got=%h exp=0", rdata0); end
        @(negedge clk);
        reset = 1'b0;
        model_reset(0);
        cyc(0, 1, 0, 1, 4'd0, 0, 0);
        checks++; if (rdata0 !== 32'h0000_0007) begin errors++; $display("FAIL reset_status got=%h exp=00000007", rdata0); end
    endtask

    task automatic test_ordered_fill;
        logic [31:0] words [4];
        words = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 4'd1, words[i], 0);
        checks++; if (full0[0] !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", full0[0]); end
        checks++; if (q0[31:0] !== 32'hA1) begin errors++; $display("FAIL fill_head got=%h exp=a1", q0[31:0]); end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 4'd0, 0, 7'b001);
            if (i < 3) begin
                checks++;
                if (q0[31:0] !== words[i + 1]) begin errors++; $display("FAIL pop_head%0d got=%h exp=%h", i, q0[31:0], words[i + 1]); end
            end else begin
                checks++;
                if (empty0[0] !== 1'b1) begin errors++; $display("FAIL pop_empty got=%b exp=1", empty0[0]); end
            end
        end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 4'd2, 32'hB0 + i, 0);
        checks++; if (full0[1] !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b exp=1", full0[1]); end
        cyc(0, 1, 1, 0, 4'd2, 32'hDEAD, 7'b010);
        checks++; if (q0[63:32] !== 32'hB1) begin errors++; $display("FAIL ovf_head got=%h exp=b1", q0[63:32]); end
        cyc(0, 1, 0, 1, 4'd9, 0, 0);
        checks++; if (rdata0 !== 32'h0001_0003) begin errors++; $display("FAIL ovf_chan got=%h exp=00010003", rdata0); end
        cyc(0, 1, 0, 1, 4'd0, 0, 0);
        checks++; if (rdata0[16] !== 1'b1) begin errors++; $display("FAIL ovf_anydrop got=%b exp=1", rdata0[16]); end
    endtask

    task automatic test_saturation;
        logic [31:0] expv;
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 4'd1, 32'hC0 + i, 0);
        for (int i = 0; i < 65540; i++) cyc(0, 1, 1, 0, 4'd1, i, 0);
        cyc(0, 1, 0, 1, 4'd8, 0, 0);
        checks++; if (rdata0 !== 32'hFFFF_0004) begin errors++; $display("FAIL sat_count got=%h exp=ffff0004", rdata0); end
        cyc(0, 1, 1, 0, 4'd15, 32'h8000_0000, 0);
        cyc(0, 1, 0, 1, 4'd8, 0, 0);
        checks++; if (rdata0 !== 32'h0000_0004) begin errors++; $display("FAIL clr_count got=%h exp=00000004", rdata0); end
        expv = exp_read(0, 4'd0);
        cyc(0, 1, 0, 1, 4'd0, 0, 0);
        checks++; if (rdata0[16] !== 1'b0) begin errors++; $display("FAIL clr_anydrop got=%b exp=0", rdata0[16]); end
        checks++; if (rdata0 !== expv) begin errors++; $display("FAIL clr_status got=%h exp=%h", rdata0, expv); end
    endtask

    task automatic test_flush_pop;
        logic [31:0] expv;
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 4'd3, 32'hE0 + i, 0);
        cyc(0, 1, 0, 1, 4'd10, 0, 0);
        checks++; if (rdata0 !== 32'h0000_0003) begin errors++; $display("FAIL flush_pre got=%h exp=00000003", rdata0); end
        cyc(0, 1, 1, 0, 4'd15, 32'h4, 7'b100);
        checks++; if (empty0[2] !== 1'b1) begin errors++; $display("FAIL flush_empty got=%b exp=1", empty0[2]); end
        cyc(0, 1, 0, 1, 4'd10, 0, 0);
        checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL flush_occ got=%h exp=0", rdata0); end
        for (int c = 0; c < 2; c++) begin
            expv = exp_read(0, 4'(8 + c));
            cyc(0, 1, 0, 1, 4'(8 + c), 0, 0);
            checks++;
            if (rdata0 !== expv) begin errors++; $display("FAIL flush_other%0d got=%h exp=%h", c, rdata0, expv); end
            checks++;
            if (q0[c*32 +: 32] !== mq[0][c][0]) begin errors++; $display("FAIL flush_head%0d got=%h exp=%h", c, q0[c*32 +: 32], mq[0][c][0]); end
        end
    endtask

    task automatic test_random;
        logic [31:0] last_rd;
        logic [31:0] expv;
        bit cs, w, r;
        logic [3:0] a;
        logic [31:0] wd;
        logic [6:0] pm;
        last_rd = rdata0;
        for (int n = 0; n < 400; n++) begin
            cs = ($urandom_range(7) != 0);
            w  = $urandom_range(1);
            r  = $urandom_range(1);
            a  = 4'($urandom_range(15));
            wd = $urandom;
            if ($urandom_range(15) != 0) wd[31] = 1'b0;
            if (a == 4'd15 && $urandom_range(3) != 0) wd[2:0] = 3'b000;
            pm = 7'($urandom_range(7));
            if ($urandom_range(1) == 0) pm = 0;
            expv = exp_read(0, a);
            cyc(0, cs, w, r, a, wd, pm);
            if (cs && r) last_rd = expv;
            checks++;
            if (rdata0 !== last_rd) begin errors++; $display("FAIL rand_rd n=%0d got=%h exp=%h", n, rdata0, last_rd); end
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (empty0[c] !== (mq[0][c].size() == 0) || full0[c] !== (mq[0][c].size() == 4)) begin
                    errors++; $display("FAIL rand_flags n=%0d c=%0d got=%b%b size=%0d", n, c, empty0[c], full0[c], mq[0][c].size());
                end
                if (mq[0][c].size() > 0) begin
                    checks++;
                    if (q0[c*32 +: 32] !== mq[0][c][0]) begin errors++; $display("FAIL rand_head n=%0d c=%0d got=%h exp=%h", n, c, q0[c*32 +: 32], mq[0][c][0]); end
                end
            end
        end
    endtask

    task automatic test_sweep;
        logic [31:0] expv;
        logic [6:0]  pm;
        logic [6:0]  empty_before;
        for (int r = 0; r < 20; r++) begin
            for (int ch = 0; ch < 7; ch++) begin
                pm = '0;
                for (int b = 0; b < 7; b++) pm[b] = ($urandom_range(7) == 0);
                cyc(1, 1, 1, 0, 4'(ch + 1), $urandom, pm);
                for (int c = 0; c < 7; c++) begin
                    checks++;
                    if (empty1[c] !== (mq[1][c].size() == 0) || full1[c] !== (mq[1][c].size() == 8)) begin
                        errors++; $display("FAIL sweep_flags r=%0d c=%0d got=%b%b size=%0d", r, c, empty1[c], full1[c], mq[1][c].size());
                    end
                    if (mq[1][c].size() > 0) begin
                        checks++;
                        if (q1[c*16 +: 16] !== 16'(mq[1][c][0])) begin errors++; $display("FAIL sweep_head r=%0d c=%0d got=%h exp=%h", r, c, q1[c*16 +: 16], 16'(mq[1][c][0])); end
                    end
                end
            end
        end
        // control write with empty mask must not push or flush anything
        empty_before = empty1;
        cyc(1, 1, 1, 0, 4'd15, 32'h0000_1234 & 32'hFFFF_FF80, 0);
        checks++; if (empty1 !== empty_before) begin errors++; $display("FAIL ctrl_nopush got=%b exp=%b", empty1, empty_before); end
        for (int c = 0; c < 7; c++) begin
            expv = exp_read(1, 4'(8 + c));
            cyc(1, 1, 0, 1, 4'(8 + c), 0, 0);
            checks++;
            if (rdata1 !== expv) begin errors++; $display("FAIL sweep_chan%0d got=%h exp=%h", c, rdata1, expv); end
        end
        expv = exp_read(1, 4'd0);
        cyc(1, 1, 0, 1, 4'd0, 0, 0);
        checks++; if (rdata1 !== expv) begin errors++; $display("FAIL sweep_status got=%h exp=%h", rdata1, expv); end
        for (int n = 0; n < 9; n++) begin
            cyc(1, 0, 0, 0, 4'd0, 0, 7'h7F);
            for (int c = 0; c < 7; c++) begin
                if (mq[1][c].size() > 0) begin
                    checks++;
                    if (q1[c*16 +: 16] !== 16'(mq[1][c][0])) begin errors++; $display("FAIL drain_head c=%0d got=%h exp=%h", c, q1[c*16 +: 16], 16'(mq[1][c][0])); end
                end
            end
        end
        checks++; if (empty1 !== 7'h7F) begin errors++; $display("FAIL drain_empty got=%b exp=1111111", empty1); end
        // unmapped reads on the 3-channel instance
        cyc(0, 1, 0, 1, 4'd0, 0, 0);
        cyc(0, 1, 0, 1, 4'd4, 0, 0);
        checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL unmapped4 got=%h exp=0", rdata0); end
        cyc(0, 1, 0, 1, 4'd0, 0, 0);
        cyc(0, 1, 0, 1, 4'd12, 0, 0);
        checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL unmapped12 got=%h exp=0", rdata0); end
    endtask

    initial begin
        test_reset();
        test_ordered_fill();
        test_overflow();
        test_saturation();
        test_flush_pop();
        test_random();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
